// File: rtl/key_event_encoder.sv
// Turns hps_io PS/2 key events into ASCII / VT100 byte sequences and queues
// them in a first-word-fall-through FIFO for the console receive path.
module key_event_encoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        caps_lock,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EMIT0 = 2'd1;
  localparam logic [1:0] ST_EMIT1 = 2'd2;
  localparam logic [1:0] ST_EMIT2 = 2'd3;

  // Lowercase / unshifted ASCII for a non-extended set-2 code, 0 if unmapped.
  function automatic logic [7:0] lower_char(input logic [7:0] code);
    case (code)
      8'h1C: lower_char = 8'h61;  8'h32: lower_char = 8'h62;
      8'h21: lower_char = 8'h63;  8'h23: lower_char = 8'h64;
      8'h24: lower_char = 8'h65;  8'h2B: lower_char = 8'h66;
      8'h34: lower_char = 8'h67;  8'h33: lower_char = 8'h68;
      8'h43: lower_char = 8'h69;  8'h3B: lower_char = 8'h6A;
      8'h42: lower_char = 8'h6B;  8'h4B: lower_char = 8'h6C;
      8'h3A: lower_char = 8'h6D;  8'h31: lower_char = 8'h6E;
      8'h44: lower_char = 8'h6F;  8'h4D: lower_char = 8'h70;
      8'h15: lower_char = 8'h71;  8'h2D: lower_char = 8'h72;
      8'h1B: lower_char = 8'h73;  8'h2C: lower_char = 8'h74;
      8'h3C: lower_char = 8'h75;  8'h2A: lower_char = 8'h76;
      8'h1D: lower_char = 8'h77;  8'h22: lower_char = 8'h78;
      8'h35: lower_char = 8'h79;  8'h1A: lower_char = 8'h7A;
      8'h45: lower_char = 8'h30;  8'h16: lower_char = 8'h31;
      8'h1E: lower_char = 8'h32;  8'h26: lower_char = 8'h33;
      8'h25: lower_char = 8'h34;  8'h2E: lower_char = 8'h35;
      8'h36: lower_char = 8'h36;  8'h3D: lower_char = 8'h37;
      8'h3E: lower_char = 8'h38;  8'h46: lower_char = 8'h39;
      8'h29: lower_char = 8'h20;  8'h5A: lower_char = 8'h0D;
      8'h66: lower_char = 8'h08;  8'h0D: lower_char = 8'h09;
      8'h76: lower_char = 8'h1B;
      default: lower_char = 8'h00;
    endcase
  endfunction

  // US-layout symbol on a shifted digit key.
  function automatic logic [7:0] shift_digit(input logic [7:0] ch);
    case (ch)
      8'h31: shift_digit = 8'h21;  8'h32: shift_digit = 8'h40;
      8'h33: shift_digit = 8'h23;  8'h34: shift_digit = 8'h24;
      8'h35: shift_digit = 8'h25;  8'h36: shift_digit = 8'h5E;
      8'h37: shift_digit = 8'h26;  8'h38: shift_digit = 8'h2A;
      8'h39: shift_digit = 8'h28;  8'h30: shift_digit = 8'h29;
      default: shift_digit = ch;
    endcase
  endfunction

  logic          armed_q, tog_q, ev_valid_q;
  logic [9:0]    ev_key_q;
  logic          pend_valid_q, pend_valid_d;
  logic [9:0]    pend_key_q, pend_key_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d;
  logic          ctrl_q, ctrl_d, caps_q, caps_d, ovf_q, ovf_d;
  logic [1:0]    state_q, state_d, len_q, len_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
  logic [CW-1:0] count_q, count_d, free_s;
  logic [7:0]    odata_q, odata_d;
  logic          ovalid_q, ovalid_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          ev_s, idle_s, dec_valid_s, shift_s, fits_s;
  logic          dec_pr_s, dec_ext_s;
  logic [7:0]    dec_code_s, ch_s;
  logic [9:0]    dec_key_s;
  logic [1:0]    seq_len_s;
  logic [7:0]    seq_b0_s, seq_b1_s, seq_b2_s, push_data_s;
  logic          push_s, pop_s, drop_pend_s, drop_seq_s;

  // The first cycle after reset only samples the toggle so a held strobe is not an event.
  assign ev_s        = armed_q & (ps2_key[10] != tog_q);
  assign idle_s      = (state_q == ST_IDLE);
  assign dec_valid_s = idle_s & (pend_valid_q | ev_valid_q);
  assign dec_key_s   = pend_valid_q ? pend_key_q : ev_key_q;
  assign dec_pr_s    = dec_key_s[9];
  assign dec_ext_s   = dec_key_s[8];
  assign dec_code_s  = dec_key_s[7:0];
  assign shift_s     = lshift_q | rshift_q;
  assign ch_s        = lower_char(dec_code_s);
  assign free_s      = CW'(FIFO_DEPTH) - count_q;
  assign fits_s      = (CW'(seq_len_s) <= free_s);
  assign pop_s       = ovalid_q & out_ready;
  assign rd_next_s   = rd_ptr_q + AW'(1);

  // Decode: modifier/caps updates and the byte sequence for one key event.
  always_comb begin
    seq_len_s = 2'd0;
    seq_b0_s  = 8'h00;
    seq_b1_s  = 8'h00;
    seq_b2_s  = 8'h00;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    ctrl_d    = ctrl_q;
    caps_d    = caps_q;
    if (!dec_valid_s) begin
      seq_len_s = 2'd0;
    end else if (!dec_ext_s && dec_code_s == 8'h12) begin
      lshift_d = dec_pr_s;
    end else if (!dec_ext_s && dec_code_s == 8'h59) begin
      rshift_d = dec_pr_s;
    end else if (dec_code_s == 8'h14) begin
      ctrl_d = dec_pr_s;
    end else if (!dec_ext_s && dec_code_s == 8'h58) begin
      caps_d = caps_q ^ dec_pr_s;
    end else if (dec_pr_s && dec_ext_s) begin
      seq_b0_s = 8'h1B;
      seq_b1_s = 8'h5B;
      case (dec_code_s)
        8'h75:   begin seq_len_s = 2'd3; seq_b2_s = 8'h41; end
        8'h72:   begin seq_len_s = 2'd3; seq_b2_s = 8'h42; end
        8'h74:   begin seq_len_s = 2'd3; seq_b2_s = 8'h43; end
        8'h6B:   begin seq_len_s = 2'd3; seq_b2_s = 8'h44; end
        default: begin seq_len_s = 2'd0; seq_b2_s = 8'h00; end
      endcase
    end else if (dec_pr_s && !dec_ext_s && ch_s != 8'h00) begin
      seq_len_s = 2'd1;
      if (ch_s >= 8'h61 && ch_s <= 8'h7A) begin
        if (ctrl_q) begin
          seq_b0_s = ch_s & 8'h1F;
        end else if (shift_s ^ caps_q) begin
          seq_b0_s = ch_s & 8'hDF;
        end else begin
          seq_b0_s = ch_s;
        end
      end else if (ch_s >= 8'h30 && ch_s <= 8'h39 && shift_s) begin
        seq_b0_s = shift_digit(ch_s);
      end else begin
        seq_b0_s = ch_s;
      end
    end else begin
      seq_len_s = 2'd0;
    end
  end

  // One-entry pending slot for events arriving while the emitter is busy.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_key_d   = pend_key_q;
    drop_pend_s  = 1'b0;
    if (idle_s) begin
      pend_valid_d = pend_valid_q & ev_valid_q;
      pend_key_d   = ev_valid_q ? ev_key_q : pend_key_q;
    end else if (ev_valid_q) begin
      if (pend_valid_q) begin
        drop_pend_s = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_key_d   = ev_key_q;
      end
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Emitter: sequences are accepted whole or dropped whole.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    drop_seq_s  = 1'b0;
    push_s      = 1'b0;
    push_data_s = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (dec_valid_s && seq_len_s != 2'd0) begin
          if (fits_s) begin
            state_d = ST_EMIT0;
            len_d   = seq_len_s;
            b0_d    = seq_b0_s;
            b1_d    = seq_b1_s;
            b2_d    = seq_b2_s;
          end else begin
            drop_seq_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT0: begin
        push_s      = 1'b1;
        push_data_s = b0_q;
        state_d     = (len_q > 2'd1) ? ST_EMIT1 : ST_IDLE;
      end
      ST_EMIT1: begin
        push_s      = 1'b1;
        push_data_s = b1_q;
        state_d     = (len_q > 2'd2) ? ST_EMIT2 : ST_IDLE;
      end
      ST_EMIT2: begin
        push_s      = 1'b1;
        push_data_s = b2_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ovf_d = ovf_q | drop_pend_s | drop_seq_s;

  // FIFO bookkeeping; the head byte is kept in a register so outputs are registered.
  always_comb begin
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_next_s : rd_ptr_q;
    ovalid_d = (count_d != '0);
    if (count_d == '0) begin
      odata_d = 8'h00;
    end else if (count_q == '0 || (pop_s && count_q == CW'(1))) begin
      odata_d = push_data_s;
    end else if (pop_s) begin
      odata_d = mem_q[rd_next_s];
    end else begin
      odata_d = odata_q;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_sys) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      armed_q      <= 1'b0;
      tog_q        <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_key_q     <= 10'd0;
      pend_valid_q <= 1'b0;
      pend_key_q   <= 10'd0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      ctrl_q       <= 1'b0;
      caps_q       <= 1'b0;
      ovf_q        <= 1'b0;
      state_q      <= ST_IDLE;
      len_q        <= 2'd0;
      b0_q         <= 8'h00;
      b1_q         <= 8'h00;
      b2_q         <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      odata_q      <= 8'h00;
      ovalid_q     <= 1'b0;
    end else begin
      armed_q      <= 1'b1;
      tog_q        <= ps2_key[10];
      ev_valid_q   <= ev_s;
      ev_key_q     <= ps2_key[9:0];
      pend_valid_q <= pend_valid_d;
      pend_key_q   <= pend_key_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      ctrl_q       <= ctrl_d;
      caps_q       <= caps_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      len_q        <= len_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      odata_q      <= odata_d;
      ovalid_q     <= ovalid_d;
    end
  end

  assign out_data  = odata_q;
  assign out_valid = ovalid_q;
  assign caps_lock = caps_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder: directed scenarios plus a
// randomized key stream checked against a keyboard-level reference model.
module tb_key_event_encoder;

  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] ps2_key = 11'd0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        caps_lock;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got [$];
  logic [7:0] exp [$];

  // reference keyboard model
  bit m_lshift, m_rshift, m_ctrl, m_caps;
  int letter_of [256];
  int digit_of [256];
  logic [7:0] special_of [256];
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] arrow_codes [4] = '{8'h75, 8'h72, 8'h74, 8'h6B};
  string sym = ")!@#$%^&*(";

  key_event_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .caps_lock (caps_lock),
    .overflow  (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (!reset && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_tables();
    for (int i = 0; i < 256; i++) begin
      letter_of[i] = -1;
      digit_of[i] = -1;
      special_of[i] = 8'h00;
    end
    for (int i = 0; i < 26; i++) letter_of[letter_codes[i]] = i;
    for (int i = 0; i < 10; i++) digit_of[digit_codes[i]] = i;
    special_of[8'h29] = 8'h20;
    special_of[8'h5A] = 8'h0D;
    special_of[8'h66] = 8'h08;
    special_of[8'h0D] = 8'h09;
    special_of[8'h76] = 8'h1B;
  endtask

  task automatic model_reset();
    m_lshift = 0; m_rshift = 0; m_ctrl = 0; m_caps = 0;
  endtask

  task automatic model_event(input bit pr, input bit ex, input logic [7:0] code);
    int c;
    bit shift;
    c = int'(code);
    shift = m_lshift || m_rshift;
    if (!ex && code == 8'h12) m_lshift = pr;
    else if (!ex && code == 8'h59) m_rshift = pr;
    else if (code == 8'h14) m_ctrl = pr;
    else if (!ex && code == 8'h58) begin
      if (pr) m_caps = !m_caps;
    end else if (pr && ex) begin
      for (int k = 0; k < 4; k++) begin
        if (arrow_codes[k] == code) begin
          exp.push_back(8'h1B);
          exp.push_back(8'h5B);
          exp.push_back(8'(65 + k));
        end
      end
    end else if (pr) begin
      if (letter_of[c] >= 0) begin
        if (m_ctrl) exp.push_back(8'(letter_of[c] + 1));
        else if (shift != m_caps) exp.push_back(8'(65 + letter_of[c]));
        else exp.push_back(8'(97 + letter_of[c]));
      end else if (digit_of[c] >= 0) begin
        if (shift) exp.push_back(8'(sym[digit_of[c]]));
        else exp.push_back(8'(48 + digit_of[c]));
      end else if (special_of[c] != 8'h00) begin
        exp.push_back(special_of[c]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input bit pr, input bit ex, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ex, code};
    model_event(pr, ex, code);
    tick();
  endtask

  task automatic press_gap(input bit pr, input bit ex, input logic [7:0] code);
    send(pr, ex, code);
    repeat (5) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    got.delete();
    exp.delete();
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", out_data); end
    vectors++; if (caps_lock !== 1'b0) begin miscompares++; $display("FAIL reset_caps got %b want 0", caps_lock); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    repeat (4) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    got.delete();
    send(1'b1, 1'b0, 8'h1C);
    tick();
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin miscompares++; $display("FAIL basic_n3 got valid=%b data=%h want 1/61", out_valid, out_data); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_n4 got valid=%b want 0", out_valid); end
    press_gap(1'b0, 1'b0, 8'h1C);
    repeat (4) tick();
    vectors++; if (got.size() !== 1) begin miscompares++; $display("FAIL basic_count got %0d want 1", got.size()); end
  endtask

  task automatic test_modifiers();
    got.delete();
    press_gap(1'b1, 1'b0, 8'h12);
    press_gap(1'b1, 1'b0, 8'h1C);
    press_gap(1'b0, 1'b0, 8'h12);
    press_gap(1'b1, 1'b0, 8'h58);
    press_gap(1'b1, 1'b0, 8'h1C);
    press_gap(1'b1, 1'b0, 8'h12);
    press_gap(1'b1, 1'b0, 8'h1C);
    vectors++; if (got.size() !== 3) begin miscompares++; $display("FAIL mod_count got %0d want 3", got.size()); end
    if (got.size() == 3) begin
      vectors++; if (got[0] !== 8'h41) begin miscompares++; $display("FAIL mod_shift got %h want 41", got[0]); end
      vectors++; if (got[1] !== 8'h41) begin miscompares++; $display("FAIL mod_caps got %h want 41", got[1]); end
      vectors++; if (got[2] !== 8'h61) begin miscompares++; $display("FAIL mod_shift_caps got %h want 61", got[2]); end
    end
    vectors++; if (caps_lock !== 1'b1) begin miscompares++; $display("FAIL mod_caps_flag got %b want 1", caps_lock); end
    press_gap(1'b0, 1'b0, 8'h12);
    press_gap(1'b0, 1'b0, 8'h58);
    vectors++; if (caps_lock !== 1'b1) begin miscompares++; $display("FAIL caps_release got %b want 1", caps_lock); end
    press_gap(1'b1, 1'b0, 8'h58);
    vectors++; if (caps_lock !== 1'b0) begin miscompares++; $display("FAIL caps_off got %b want 0", caps_lock); end
  endtask

  task automatic test_ctrl_arrow();
    got.delete();
    press_gap(1'b1, 1'b0, 8'h14);
    press_gap(1'b1, 1'b0, 8'h21);
    press_gap(1'b0, 1'b0, 8'h14);
    vectors++; if (got.size() !== 1 || got[0] !== 8'h03) begin miscompares++; $display("FAIL ctrl_c got n=%0d first=%h want 1/03", got.size(), (got.size() > 0) ? got[0] : 8'h00); end
    send(1'b1, 1'b1, 8'h75);
    tick();
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h1B) begin miscompares++; $display("FAIL arrow_b0 got %b/%h want 1/1b", out_valid, out_data); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h5B) begin miscompares++; $display("FAIL arrow_b1 got %b/%h want 1/5b", out_valid, out_data); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin miscompares++; $display("FAIL arrow_b2 got %b/%h want 1/41", out_valid, out_data); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arrow_end got %b want 0", out_valid); end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) press_gap(1'b1, 1'b0, 8'h1C);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fifo_pre_ovf got %b want 0", overflow); end
    press_gap(1'b1, 1'b1, 8'h75);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fifo_ovf got %b want 1", overflow); end
    vectors++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin miscompares++; $display("FAIL fifo_hold got %b/%h want 1/61", out_valid, out_data); end
    out_ready = 1'b1;
    repeat (12) tick();
    vectors++; if (got.size() !== 7) begin miscompares++; $display("FAIL fifo_drain_count got %0d want 7", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++; if (got[i] !== 8'h61) begin miscompares++; $display("FAIL fifo_drain_byte%0d got %h want 61", i, got[i]); end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    want = '{8'h1B, 8'h5B, 8'h41, 8'h61};
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 1'b1, 8'h75);
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h32);
    repeat (12) tick();
    vectors++; if (got.size() !== 4) begin miscompares++; $display("FAIL b2b_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vectors++; if (got[i] !== want[i]) begin miscompares++; $display("FAIL b2b_byte%0d got %h want %h", i, got[i], want[i]); end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL b2b_ovf got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    if (ps2_key[10] == 1'b1) press_gap(1'b0, 1'b0, 8'h1C);
    send(1'b1, 1'b1, 8'h75);
    tick();
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL mid_reset got valid=%b ovf=%b want 0/0", out_valid, overflow); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL mid_reset_data got %h want 00", out_data); end
    tick();
    tick();
    got.delete();
    exp.delete();
    model_reset();
    reset = 1'b0;
    repeat (10) tick();
    vectors++; if (got.size() !== 0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_spurious got n=%0d valid=%b want 0/0", got.size(), out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] pool_code [53];
    bit         pool_ext [53];
    int n, sel, guard;
    bit pr;
    n = 0;
    for (int i = 0; i < 26; i++) begin pool_code[n] = letter_codes[i]; pool_ext[n] = 0; n++; end
    for (int i = 0; i < 10; i++) begin pool_code[n] = digit_codes[i]; pool_ext[n] = 0; n++; end
    pool_code[n] = 8'h29; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h5A; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h66; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h0D; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h76; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h12; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h59; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h14; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h14; pool_ext[n] = 1; n++;
    pool_code[n] = 8'h58; pool_ext[n] = 0; n++;
    for (int i = 0; i < 4; i++) begin pool_code[n] = arrow_codes[i]; pool_ext[n] = 1; n++; end
    pool_code[n] = 8'h05; pool_ext[n] = 0; n++;
    pool_code[n] = 8'h7E; pool_ext[n] = 0; n++;
    do_reset();
    for (int it = 0; it < 300; it++) begin
      guard = 0;
      while ((exp.size() - got.size()) > DEPTH - 3 && guard < 50) begin
        out_ready = 1'b1;
        tick();
        guard++;
      end
      sel = int'($urandom_range(0, n - 1));
      pr = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      send(pr, pool_ext[sel], pool_code[sel]);
      for (int k = 0; k < 5; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    out_ready = 1'b1;
    repeat (20) tick();
    vectors++; if (got.size() !== exp.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL rand_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rand_ovf got %b want 0", overflow); end
    vectors++; if (caps_lock !== m_caps) begin miscompares++; $display("FAIL rand_caps got %b want %b", caps_lock, m_caps); end
  endtask

  initial begin
    init_tables();
    model_reset();
    test_reset();
    test_basic();
    test_modifiers();
    test_ctrl_arrow();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output FIFO depth in bytes (power of two, ≥4).
REQ-002 clk_sys  input  1  system clock (100 MHz); all logic is in this domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ps2_key  input  11  hps_io key event: [10] toggle strobe, [9] pressed, [8] extended (E0), [7:0] set-2 scan code.
REQ-005 out_data  output  8  byte to the console receive path.
REQ-006 out_valid  output  1  out_data holds a valid byte.
REQ-007 out_ready  input  1  consumer accepts; a byte transfers on a cycle with out_valid & out_ready.
REQ-008 caps_lock  output  1  current caps-lock state.
REQ-009 overflow  output  1  sticky; a byte or event was dropped.

Function
REQ-010 Event detect: an event occurs on each cycle where ps2_key[10] differs from its registered previous value.
REQ-011 First cycle after reset release: capture ps2_key[10] into the previous-value register, no event.
REQ-012 Modifiers: 0x12 and 0x59 drive left/right shift; 0x14 drives ctrl (E0 or not), set on press and cleared on release; shift = L|R.
REQ-013 Caps: press of 0x58 toggles caps_lock; release ignored.
REQ-014 Releases of non-modifier keys produce no output.
REQ-015 Single-byte map on press: set-2 codes for a-z, 0-9, space (0x29→0x20), enter (0x5A→0x0D), backspace (0x66→0x08), tab (0x0D→0x09), esc (0x76→0x1B); shifted digits give US symbols (!@#$%^&*()).
REQ-016 Letters: uppercase iff shift XOR caps_lock; caps_lock does not affect digits.
REQ-017 Ctrl held with a letter: emit (lowercase ASCII & 0x1F), e.g. ctrl+c → 0x03; ctrl overrides shift and caps.
REQ-018 Extended arrows (bit8=1): 0x75 → 1B 5B 41, 0x72 → 1B 5B 42, 0x74 → 1B 5B 43, 0x6B → 1B 5B 44.
REQ-019 Unmapped codes: no output and no overflow.
REQ-020 Pipeline: event at cycle N, decode is registered at N+1, first byte is written to the FIFO at N+2, and later bytes follow at N+3 and N+4.
REQ-021 Emitter states: IDLE, EMIT0, EMIT1, EMIT2; IDLE→EMIT0 on a decoded sequence; EMITk→EMITk+1 while bytes remain, else →IDLE.
REQ-022 Atomic write: at IDLE→EMIT0, if FIFO free space < sequence length, drop the whole sequence, set overflow, and stay IDLE.
REQ-023 Event during a non-IDLE emitter: hold it in a one-entry pending register, decoded on return to IDLE; if pending is already full, drop the new event and set overflow.
REQ-024 Modifier and caps state update at decode time, in event order, including events that come from pending.
REQ-025 FIFO is first-word-fall-through: a write to an empty FIFO at cycle M gives out_valid=1 at M+1.
REQ-026 While out_valid=1 and out_ready=0, out_data is held stable.
REQ-027 Simultaneous push and pop in one cycle is allowed at any fill level, including full; the count is unchanged.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; the count uses log2(FIFO_DEPTH)+1 bits.

Reset
REQ-029 When reset is asserted, these are cleared immediately: out_valid=0, out_data=0x00, caps_lock=0, overflow=0, shift=0, ctrl=0, FIFO empty, pending empty, emitter IDLE.
REQ-030 Reset mid-sequence discards the remaining bytes; no partial sequence is emitted after release.
REQ-031 overflow clears only on reset.

Verification
REQ-032 Press 0x1C with out_ready=1 → at N+3 out_data=0x61 with out_valid for one cycle; release 0x1C → no output.
REQ-033 Press 0x12, press 0x1C, release 0x12, press 0x58, press 0x1C → 0x41, then 0x41 (caps); then shift+caps+0x1C → 0x61.
REQ-034 Press 0x14, press 0x21 → 0x03; ext press 0x75 → 1B 5B 41 on consecutive cycles.
REQ-035 out_ready=0 with FIFO_DEPTH=8: seven 'a' presses then one up-arrow → up-arrow dropped, overflow=1, FIFO holds 7×0x61; draining yields exactly seven bytes.
REQ-036 Two events one cycle apart during EMIT1 of an arrow → the first is emitted after the arrow, the third back-to-back event sets overflow.
REQ-037 Assert reset during EMIT1 → out_valid=0 and overflow=0 immediately; with ps2_key[10]=1 held through release → no spurious event.
